// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer and the branch comparator:
// sequencer FSM states, next-PC select codes, branch-op encodings, and the
// default sequential PC increment.
package pc_seq_pkg;

    localparam int unsigned DEFAULT_PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_TGT  = 2'd2
    } pc_sel_t;

    // Branch-op encodings shared with the branch comparator
    localparam logic [2:0] BR  = 3'b000;
    localparam logic [2:0] BMI = 3'b001;
    localparam logic [2:0] BPL = 3'b010;
    localparam logic [2:0] BZ  = 3'b011;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: hold, sequential (pc+PC_STEP, modulo
// 2^PC_WIDTH) or word-aligned branch target.
// Ports:
//   sel_i       select code (hold / seq / target)
//   pc_i        current PC
//   br_target_i raw branch target (low two bits are dropped)
//   pc_seq_c    pc_i + PC_STEP
//   pc_next_c   selected next PC
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  pc_sel_t               sel_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [PC_WIDTH-1:0]   br_target_i,
    output logic [PC_WIDTH-1:0]   pc_seq_c,
    output logic [PC_WIDTH-1:0]   pc_next_c
);

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    // Next-PC selection
    always_comb begin
        pc_seq_c  = pc_i + STEP;
        pc_next_c = pc_i;
        case (sel_i)
            SEL_SEQ: pc_next_c = pc_seq_c;
            SEL_TGT: pc_next_c = br_target_i & ALIGN_MASK;
            default: pc_next_c = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer. Holds the PC, fetches one instruction
// over a req/ack handshake, presents it to decode, then picks the next PC
// (sequential, aligned branch target, or halt).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   stall                       decode hazard hold (freezes ISSUE)
//   br_valid, is_branch         branch resolves / taken
//   br_target                   branch destination
//   halt                        decoded halt
//   imem_req, imem_addr         fetch request / address
//   imem_ack, imem_rdata        fetch response
//   instr, instr_valid          instruction to decode
//   pc_out, link_pc             address of instr, and address + PC_STEP
//   halted                      core halted
// Optional feature: define BR_COUNT_EN to add br_taken_cnt[31:0], a count
// of taken branches leaving ISSUE (not counted when halt wins).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                br_valid,
    input  logic                is_branch,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                halt,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] link_pc,
    output logic                halted
`ifdef BR_COUNT_EN
    ,
    output logic [31:0]         br_taken_cnt
`endif
);

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;
    logic [PC_WIDTH-1:0]   link_pc_q, link_pc_d;
    logic                  imem_req_q, imem_req_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  halted_q, halted_d;
    logic                  take_br_c;
    pc_sel_t               pc_sel;
    logic [PC_WIDTH-1:0]   pc_seq_c, pc_next_c;

    pc_next_mux #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_next_mux (
        .sel_i       (pc_sel),
        .pc_i        (pc_q),
        .br_target_i (br_target),
        .pc_seq_c    (pc_seq_c),
        .pc_next_c   (pc_next_c)
    );

    // A taken branch leaving ISSUE; halt wins over a branch
    assign take_br_c = (state_q == ISSUE) && !stall && !halt && br_valid && is_branch;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        pc_sel    = SEL_HOLD;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        link_pc_d = link_pc_q;
        case (state_q)
            FETCH: begin
                // Ack only counts once the request is actually on the bus
                if (imem_req_q && imem_ack) begin
                    state_d   = ISSUE;
                    instr_d   = imem_rdata;
                    pc_out_d  = pc_q;
                    link_pc_d = pc_seq_c;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                        pc_sel  = take_br_c ? SEL_TGT : SEL_SEQ;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        pc_d          = pc_next_c;
        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == ISSUE);
        halted_d      = (state_d == HALT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            pc_out_q      <= '0;
            link_pc_q     <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            link_pc_q     <= link_pc_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

`ifdef BR_COUNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;

    // Taken-branch counter, wraps at 2^32
    always_comb begin
        br_cnt_d = br_cnt_q;
        if (take_br_c) begin
            br_cnt_d = br_cnt_q + 32'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    assign br_taken_cnt = br_cnt_q;
`endif

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign link_pc     = link_pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against an instruction-level
// model. A second instance starting at 0xFFFFFFFC covers PC wrap-around.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, br_valid, is_branch, halt, imem_ack;
    logic [31:0] br_target, imem_rdata;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc_out, link_pc;

    logic        w_imem_req, w_instr_valid, w_halted;
    logic [31:0] w_imem_addr, w_instr, w_pc_out, w_link_pc;
`ifdef BR_COUNT_EN
    logic [31:0] br_taken_cnt, w_br_taken_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Instruction-level model
    logic [31:0] m_pc, m_instr, m_pc_out, m_link, m_cnt;
    logic        m_req, m_valid, m_halted;

    pc_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .is_branch   (is_branch),
        .br_target   (br_target),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .link_pc     (link_pc),
        .halted      (halted)
`ifdef BR_COUNT_EN
        ,
        .br_taken_cnt(br_taken_cnt)
`endif
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (1'b0),
        .br_valid    (1'b0),
        .is_branch   (1'b0),
        .br_target   (32'h0),
        .halt        (1'b0),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_ack    (1'b1),
        .imem_rdata  (32'hA5A5_0000),
        .instr       (w_instr),
        .instr_valid (w_instr_valid),
        .pc_out      (w_pc_out),
        .link_pc     (w_link_pc),
        .halted      (w_halted)
`ifdef BR_COUNT_EN
        ,
        .br_taken_cnt(w_br_taken_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0; m_link = 32'h0; m_cnt = 32'h0;
        m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One clock of the instruction stream: wait for fetch, present, then move on
    task automatic model_edge();
        if (m_halted) begin
            m_req = 1'b0;
        end else if (m_valid) begin
            if (!stall) begin
                m_valid = 1'b0;
                if (halt) begin
                    m_halted = 1'b1;
                end else begin
                    m_req = 1'b1;
                    if (br_valid && is_branch) begin
                        m_pc  = {br_target[31:2], 2'b00};
                        m_cnt = m_cnt + 1;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end else if (m_req && imem_ack) begin
            m_instr  = imem_rdata;
            m_pc_out = m_pc;
            m_link   = m_pc + 32'd4;
            m_valid  = 1'b1;
            m_req    = 1'b0;
        end else begin
            m_req = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("imem_req", imem_req, m_req);
        if (m_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", instr_valid, m_valid);
        check("halted", halted, m_halted);
        check("instr", instr, m_instr);
        check("pc_out", pc_out, m_pc_out);
        check("link_pc", link_pc, m_link);
`ifdef BR_COUNT_EN
        check("br_taken_cnt", br_taken_cnt, m_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge: async reset, check, release at the next negedge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_req_drop", imem_req, 32'h0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; is_branch = 1'b0; br_target = 32'h0;
        halt = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1000_0001;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch with ack tied high
        step();
        check("t1_req0", imem_req, 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        check("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        step();
        check("t1_valid0", instr_valid, 32'h1);
        check("t1_instr0", instr, 32'h1000_0001);
        check("t1_link0", link_pc, 32'h4);
        check("wrap_link", w_link_pc, 32'h0);
        imem_rdata = 32'h1000_0002;
        step();
        check("t1_addr1", imem_addr, 32'h4);
        check("wrap_addr1", w_imem_addr, 32'h0);
        step();
        check("t1_pc1", pc_out, 32'h4);
        step();
        check("t1_addr2", imem_addr, 32'h8);
        step();
        check("t1_pc2", pc_out, 32'h8);
        check("t1_link2", link_pc, 32'hC);

        // Taken branch, aligned and unaligned targets
        br_valid = 1'b1; is_branch = 1'b1; br_target = 32'h40;
        step();
        check("t2_addr40", imem_addr, 32'h40);
        br_valid = 1'b0; is_branch = 1'b0;
        step();
        br_valid = 1'b1; is_branch = 1'b1; br_target = 32'h8;
        step();
        br_valid = 1'b0; is_branch = 1'b0;
        step();
        check("t2_pc8", pc_out, 32'h8);
        br_valid = 1'b1; is_branch = 1'b1; br_target = 32'h43;
        step();
        check("t2_addr43", imem_addr, 32'h40);
        br_valid = 1'b0; is_branch = 1'b0;
        step();
        br_valid = 1'b1; is_branch = 1'b1; br_target = 32'h8;
        step();
        br_valid = 1'b0; is_branch = 1'b0;
        step();

        // Not-taken branch
        br_valid = 1'b1; is_branch = 1'b0; br_target = 32'h40;
        step();
        check("t3_addrC", imem_addr, 32'hC);
        br_valid = 1'b0;
        step();

        // Stall in ISSUE
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_valid", instr_valid, 32'h1);
            check("t4_pc", pc_out, 32'hC);
            check("t4_req", imem_req, 32'h0);
        end
        stall = 1'b0;
        step();
        check("t4_addr10", imem_addr, 32'h10);
        step();

        // Halt beats a simultaneous taken branch
        halt = 1'b1; br_valid = 1'b1; is_branch = 1'b1; br_target = 32'h80;
        step();
        check("t5_halted", halted, 32'h1);
`ifdef BR_COUNT_EN
        check("t5_cnt", br_taken_cnt, 32'd4);
`endif
        halt = 1'b0; br_valid = 1'b0; is_branch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_req", imem_req, 32'h0);
        end

        // Reset mid-fetch with a delayed ack, late ack after release
        do_reset();
        imem_ack = 1'b0;
        step();
        step();
        check("t6_req", imem_req, 32'h1);
        imem_ack = 1'b1;
        do_reset();
        step();
        check("t6_noacc", instr_valid, 32'h0);
        check("t6_addr", imem_addr, 32'h0);
        step();
        check("t6_pc", pc_out, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            stall      = ($urandom_range(0, 9) < 3);
            br_valid   = ($urandom_range(0, 9) < 4);
            is_branch  = 1'($urandom_range(0, 1));
            br_target  = $urandom;
            halt       = ($urandom_range(0, 99) < 2);
            imem_ack   = ($urandom_range(0, 9) < 6);
            imem_rdata = $urandom;
            if ($urandom_range(0, 149) == 0 || (m_halted && $urandom_range(0, 3) == 0)) begin
                do_reset();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
